vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator, successor to the fixed 640x480@60 Hz controller. Produces HSYNC/VSYNC with configurable polarity, pixel coordinates, the `video_on` flag, frame/line/vblank strobes, and a line-prefetch request for upstream line buffers. All outputs are registered and mutually aligned. The block sits between the pixel clock domain root and the framebuffer/renderer logic.

## Interface
- `H_DISPLAY`, default 640: active pixels per line.
- `H_FP` / `H_SYNC` / `H_BP`, default 16 / 96 / 48: horizontal porches and sync, in pixels.
- `V_DISPLAY`, default 480: active lines.
- `V_FP` / `V_SYNC` / `V_BP`, default 10 / 2 / 33: vertical porches and sync, in lines.
- `H_SYNC_POL` / `V_SYNC_POL`, default 0 / 0: asserted sync level (0 = active-low).
- `COORD_W`, default 10: width of the coordinate outputs and internal counters.
- `PREFETCH`, default 32: number of cycles before end of line at which `line_req` fires; range 1..H_BP+H_FP+H_SYNC.
- `pixel_clk` input 1: pixel clock; all logic runs on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: advance timing when high; freeze when low.
- `h_sync` output 1: horizontal sync at `H_SYNC_POL` when asserted.
- `v_sync` output 1: vertical sync at `V_SYNC_POL` when asserted.
- `video_on` output 1: inside the active area.
- `pixel_x` output COORD_W: horizontal count, 0..H_TOTAL-1.
- `pixel_y` output COORD_W: vertical count, 0..V_TOTAL-1.
- `line_start` output 1: one-cycle pulse at `pixel_x==0` of each active line.
- `frame_over` output 1: one-cycle pulse at `h==0`, `v==V_DISPLAY+V_FP` (buffer swap point).
- `vblank` output 1: high while `pixel_y >= V_DISPLAY`.
- `line_req` output 1: one-cycle prefetch pulse for the next active line.
- `req_y` output COORD_W: line index requested by `line_req`; holds its value between pulses.

## Operation
- Constants: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP and V_TOTAL = the vertical equivalent. Elaboration fails if either exceeds 2^COORD_W or if PREFETCH is out of range.
- Internal `h_cnt` counts 0..H_TOTAL-1 and wraps. At the wrap, `v_cnt` increments; `v_cnt` wraps from V_TOTAL-1 to 0. No other states exist.
- Decode works from the current (`h_cnt`, `v_cnt`). Every output is registered from that decode in the same cycle, so all outputs describe one coordinate pair.
- Sync is asserted for `h_cnt` in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC) and for `v_cnt` in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC).
- `line_req` fires when `h_cnt == H_TOTAL-PREFETCH` and the next line index (`v_cnt+1`, wrapped to 0 at V_TOTAL) is below V_DISPLAY. `req_y` loads that index in the same cycle.
- The prefetch for line 0 is issued during line V_TOTAL-1.
- When `enable` is low:
  - counters and level outputs hold their values;
  - `line_start`, `frame_over` and `line_req` are forced to 0.
  - When `enable` returns high, counting resumes from the held position with no pulse lost or duplicated. A pulse coordinate reached exactly on the resume cycle fires once.

## Timing
- Reset (asynchronous assert, synchronous release via `pixel_clk`):
  - counters = 0;
  - `pixel_x` = `pixel_y` = 0, `req_y` = 0;
  - `video_on`, `line_start`, `frame_over`, `line_req`, `vblank` = 0;
  - `h_sync` = ~H_SYNC_POL, `v_sync` = ~V_SYNC_POL.
- Latency is one cycle from counter to outputs.
  - The first edge after reset release loads the outputs for (0,0): `video_on`=1 and `line_start`=1.
- Reset asserted mid-frame returns all outputs to their reset values immediately, without waiting for a clock edge.
- Frame period is H_TOTAL*V_TOTAL enabled cycles: 420000 with the defaults.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN`:
  - Defined: adds output `frame_cnt` [15:0]. It resets to 0, increments on the same edge that registers `frame_over`=1, and wraps 65535 to 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `vga_pkg` holds:
  - the default 640x480@60 timing constants;
  - the H_TOTAL/V_TOTAL derivation function;
  - the polarity encodings.
- One sub-module, `vga_axis_counter`: a generic wrapping counter with `tick` in, `wrap` out and range/compare decode. It is instantiated twice, for the horizontal and vertical axes.

## Test plan
- Defaults, reset release, 2 frames:
  - `h_sync` low for exactly 96 cycles per line, starting at `pixel_x`=656;
  - `v_sync` low for 2 lines starting at `pixel_y`=490;
  - frame period 420000 cycles.
- Defaults: `video_on` count per frame = 307200; `line_start` = 480 pulses; `frame_over` = 1 pulse, at (0,490).
- Defaults with PREFETCH=32:
  - `line_req` at `pixel_x`=768 on lines 0..478 with `req_y` = line+1;
  - on line 524 with `req_y`=0;
  - none on lines 479..523.
- Small mode (H 8/2/2/2, V 4/1/1/1, H_SYNC_POL=1): `h_sync` high for `pixel_x` 10..11; frame = 98 cycles.
- `enable` held low for 50 cycles at `pixel_x`=655, then released:
  - outputs frozen with no pulses during the hold;
  - sync asserts on the following enabled cycle;
  - frame length = 420000 enabled cycles.
- `reset_n` pulsed low mid-line at (300,200): outputs go to reset values without a clock edge; restart at (0,0). With `VGA_TIMING_FRAME_CNT_EN` defined, `frame_cnt`=0.

Source files
------------

// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the raster timing generator:
//   - default 640x480@60 Hz timing constants
//   - axis_total(): derives H_TOTAL / V_TOTAL from display, porches and sync
//   - sync polarity encodings
// ----------------------------------------------------------------------------
package vga_pkg;

    // Sync polarity: the level driven while the sync pulse is asserted.
    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    localparam int DEF_H_DISPLAY  = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_DISPLAY  = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam bit DEF_H_SYNC_POL = 1'b0;
    localparam bit DEF_V_SYNC_POL = 1'b0;
    localparam int DEF_COORD_W    = 10;
    localparam int DEF_PREFETCH   = 32;

    // Total positions along one axis, blanking included.
    function automatic int axis_total(input int display, input int fp,
                                      input int sync, input int bp);
        return display + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
// Generic wrapping position counter for one raster axis, with range decode.
// Counts 0..TOTAL-1 on each tick and wraps to 0.
// Ports:
//   clk_i     : clock (rising edge)
//   rst_n_i   : asynchronous active-low reset, counter -> 0
//   tick_i    : advance by one position
//   cnt_o     : current position
//   wrap_o    : position is TOTAL-1 (the next tick wraps)
//   active_o  : position < DISPLAY
//   sync_o    : position in [SYNC_START, SYNC_END)
//   hit_o     : position == HIT
// ----------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int W          = 10,
    parameter int TOTAL      = 800,
    parameter int DISPLAY    = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int HIT        = 768
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         tick_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o,
    output logic         hit_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [31:0]  cnt_ext_s;

    // Compare in 32 bits so SYNC_END == 2^W cannot alias to zero.
    assign cnt_ext_s = 32'(cnt_q);
    assign cnt_o     = cnt_q;
    assign wrap_o    = (cnt_q == LAST);
    assign active_o  = (cnt_ext_s < 32'(DISPLAY));
    assign sync_o    = (cnt_ext_s >= 32'(SYNC_START)) && (cnt_ext_s < 32'(SYNC_END));
    assign hit_o     = (cnt_ext_s == 32'(HIT));

    // Next position: hold, increment, or wrap at the last position.
    always_comb begin
        cnt_d = cnt_q;
        if (tick_i) begin
            if (wrap_o) begin
                cnt_d = {W{1'b0}};
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Position register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator. Every output is registered from the
// decode of the same (h, v) counter pair, one cycle behind the counters.
// Ports:
//   pixel_clk  : pixel clock (rising edge)
//   reset_n    : asynchronous active-low reset
//   enable     : advance when high; counters and levels freeze, pulses drop
//   h_sync     : horizontal sync, H_SYNC_POL while asserted
//   v_sync     : vertical sync, V_SYNC_POL while asserted
//   video_on   : inside the active area
//   pixel_x/y  : registered coordinates
//   line_start : pulse at x==0 of each active line
//   frame_over : pulse at (0, V_DISPLAY+V_FP), the buffer swap point
//   vblank     : y >= V_DISPLAY
//   line_req   : prefetch pulse PREFETCH cycles before end of line when the
//                next line is active
//   req_y      : index of the line requested, held between pulses
//   frame_cnt  : (only with VGA_TIMING_FRAME_CNT_EN) count of frame_over pulses
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY  = DEF_H_DISPLAY,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_DISPLAY  = DEF_V_DISPLAY,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = DEF_H_SYNC_POL,
    parameter bit V_SYNC_POL = DEF_V_SYNC_POL,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int PREFETCH   = DEF_PREFETCH
) (
    input  logic               pixel_clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic               h_sync,
    output logic               v_sync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_over,
    output logic               vblank,
    output logic               line_req,
    output logic [COORD_W-1:0] req_y
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int H_TOTAL      = axis_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = axis_total(V_DISPLAY, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = H_DISPLAY + H_FP;
    localparam int V_SYNC_START = V_DISPLAY + V_FP;

    if (H_TOTAL > (1 << COORD_W)) begin : g_bad_h_total
        $fatal(1, "vga_timing_gen: H_TOTAL does not fit in COORD_W");
    end
    if (V_TOTAL > (1 << COORD_W)) begin : g_bad_v_total
        $fatal(1, "vga_timing_gen: V_TOTAL does not fit in COORD_W");
    end
    if ((PREFETCH < 1) || (PREFETCH > H_FP + H_SYNC + H_BP)) begin : g_bad_prefetch
        $fatal(1, "vga_timing_gen: PREFETCH out of range");
    end

    logic [COORD_W-1:0] h_cnt_s, v_cnt_s, v_next_s;
    logic               h_wrap_s, h_active_s, h_in_sync_s, h_req_pos_s;
    logic               v_wrap_s, v_active_s, v_in_sync_s, v_swap_line_s;
    logic               v_tick_s;

    assign v_tick_s = enable && h_wrap_s;

    vga_axis_counter #(
        .W(COORD_W), .TOTAL(H_TOTAL), .DISPLAY(H_DISPLAY),
        .SYNC_START(H_SYNC_START), .SYNC_END(H_SYNC_START + H_SYNC),
        .HIT(H_TOTAL - PREFETCH)
    ) u_h_cnt (
        .clk_i(pixel_clk), .rst_n_i(reset_n), .tick_i(enable),
        .cnt_o(h_cnt_s), .wrap_o(h_wrap_s), .active_o(h_active_s),
        .sync_o(h_in_sync_s), .hit_o(h_req_pos_s)
    );

    vga_axis_counter #(
        .W(COORD_W), .TOTAL(V_TOTAL), .DISPLAY(V_DISPLAY),
        .SYNC_START(V_SYNC_START), .SYNC_END(V_SYNC_START + V_SYNC),
        .HIT(V_SYNC_START)
    ) u_v_cnt (
        .clk_i(pixel_clk), .rst_n_i(reset_n), .tick_i(v_tick_s),
        .cnt_o(v_cnt_s), .wrap_o(v_wrap_s), .active_o(v_active_s),
        .sync_o(v_in_sync_s), .hit_o(v_swap_line_s)
    );

    logic h_zero_s, line_start_s, frame_over_s, line_req_s;

    // Pulse decode; the prefetch for line 0 comes from the last line of the frame.
    always_comb begin
        h_zero_s = (h_cnt_s == {COORD_W{1'b0}});
        if (v_wrap_s) begin
            v_next_s = {COORD_W{1'b0}};
        end else begin
            v_next_s = v_cnt_s + COORD_W'(1);
        end
        line_start_s = h_zero_s && v_active_s;
        frame_over_s = h_zero_s && v_swap_line_s;
        line_req_s   = h_req_pos_s && (32'(v_next_s) < 32'(V_DISPLAY));
    end

    logic               h_sync_q, v_sync_q, video_on_q, vblank_q;
    logic               line_start_q, frame_over_q, line_req_q;
    logic [COORD_W-1:0] pixel_x_q, pixel_y_q, req_y_q;

    // Output registers: levels hold and pulses drop while enable is low.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_sync_q     <= ~H_SYNC_POL;
            v_sync_q     <= ~V_SYNC_POL;
            video_on_q   <= 1'b0;
            vblank_q     <= 1'b0;
            line_start_q <= 1'b0;
            frame_over_q <= 1'b0;
            line_req_q   <= 1'b0;
            pixel_x_q    <= {COORD_W{1'b0}};
            pixel_y_q    <= {COORD_W{1'b0}};
            req_y_q      <= {COORD_W{1'b0}};
        end else if (enable) begin
            h_sync_q     <= h_in_sync_s ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_q     <= v_in_sync_s ? V_SYNC_POL : ~V_SYNC_POL;
            video_on_q   <= h_active_s && v_active_s;
            vblank_q     <= ~v_active_s;
            line_start_q <= line_start_s;
            frame_over_q <= frame_over_s;
            line_req_q   <= line_req_s;
            pixel_x_q    <= h_cnt_s;
            pixel_y_q    <= v_cnt_s;
            if (line_req_s) begin
                req_y_q <= v_next_s;
            end else begin
                req_y_q <= req_y_q;
            end
        end else begin
            line_start_q <= 1'b0;
            frame_over_q <= 1'b0;
            line_req_q   <= 1'b0;
        end
    end

    assign h_sync     = h_sync_q;
    assign v_sync     = v_sync_q;
    assign video_on   = video_on_q;
    assign vblank     = vblank_q;
    assign line_start = line_start_q;
    assign frame_over = frame_over_q;
    assign line_req   = line_req_q;
    assign pixel_x    = pixel_x_q;
    assign pixel_y    = pixel_y_q;
    assign req_y      = req_y_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Frame counter steps on the same edge that registers frame_over.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 16'd0;
        end else if (enable && frame_over_s) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_q <= frame_cnt_q;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share clock, reset and a randomised enable:
//   small  : H 8/2/2/2, V 4/1/1/1, H_SYNC_POL=1, PREFETCH=3 (98-cycle frame)
//   medium : H 40/4/6/5, V 20/2/3/4, active-low syncs, PREFETCH=10
// Expected outputs come from the number of enabled edges since reset: the
// raster position is that count modulo the frame size, split into (x, y).
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        int hd; int hfp; int hsw; int hbp;
        int vd; int vfp; int vsw; int vbp;
        bit hpol; bit vpol; int pf;
    } cfg_t;

    typedef struct packed {
        int x; int y;
        bit von; bit hs; bit vs; bit ls; bit fo; bit vb; bit lr;
        int ry; int fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;

    always #5 clk = ~clk;

    logic [3:0] s_px, s_py, s_ry;
    logic       s_hs, s_vs, s_von, s_ls, s_fo, s_vb, s_lr;
    logic [5:0] m_px, m_py, m_ry;
    logic       m_hs, m_vs, m_von, m_ls, m_fo, m_vb, m_lr;
    logic [15:0] s_fc, m_fc;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .COORD_W(4), .PREFETCH(3)
    ) u_dut_s (
        .pixel_clk(clk), .reset_n(reset_n), .enable(enable),
        .h_sync(s_hs), .v_sync(s_vs), .video_on(s_von),
        .pixel_x(s_px), .pixel_y(s_py), .line_start(s_ls),
        .frame_over(s_fo), .vblank(s_vb), .line_req(s_lr), .req_y(s_ry)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    vga_timing_gen #(
        .H_DISPLAY(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_DISPLAY(20), .V_FP(2), .V_SYNC(3), .V_BP(4),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COORD_W(6), .PREFETCH(10)
    ) u_dut_m (
        .pixel_clk(clk), .reset_n(reset_n), .enable(enable),
        .h_sync(m_hs), .v_sync(m_vs), .video_on(m_von),
        .pixel_x(m_px), .pixel_y(m_py), .line_start(m_ls),
        .frame_over(m_fo), .vblank(m_vb), .line_req(m_lr), .req_y(m_ry)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(m_fc)
`endif
    );

`ifndef VGA_TIMING_FRAME_CNT_EN
    assign s_fc = 16'd0;
    assign m_fc = 16'd0;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_en     = 0;
    int   s_last_fo = -1;
    int   m_last_fo = -1;
    cfg_t cs, cm;
    exp_t e_s, e_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, want);
        end
    endtask

    function automatic exp_t reset_exp(input cfg_t c);
        exp_t e;
        e.x = 0; e.y = 0; e.von = 1'b0; e.hs = !c.hpol; e.vs = !c.vpol;
        e.ls = 1'b0; e.fo = 1'b0; e.vb = 1'b0; e.lr = 1'b0; e.ry = 0; e.fc = 0;
        return e;
    endfunction

    // Outputs after an edge; n is the count of enabled edges before this one.
    function automatic exp_t next_exp(input exp_t prev, input bit adv, input int n, input cfg_t c);
        exp_t e;
        int ht, vt, p, x, y;
        e = prev;
        e.ls = 1'b0; e.fo = 1'b0; e.lr = 1'b0;
        if (adv) begin
            ht = c.hd + c.hfp + c.hsw + c.hbp;
            vt = c.vd + c.vfp + c.vsw + c.vbp;
            p = n % (ht * vt);
            x = p % ht;
            y = p / ht;
            e.x   = x;
            e.y   = y;
            e.von = (x < c.hd) && (y < c.vd);
            e.hs  = (x >= c.hd + c.hfp && x < c.hd + c.hfp + c.hsw) ? c.hpol : !c.hpol;
            e.vs  = (y >= c.vd + c.vfp && y < c.vd + c.vfp + c.vsw) ? c.vpol : !c.vpol;
            e.ls  = (x == 0) && (y < c.vd);
            e.fo  = (x == 0) && (y == c.vd + c.vfp);
            e.vb  = (y >= c.vd);
            e.lr  = (x == ht - c.pf) && (((y + 1) % vt) < c.vd);
            if (e.lr) e.ry = (y + 1) % vt;
            if (e.fo) e.fc = (e.fc + 1) % 65536;
        end
        return e;
    endfunction

    task automatic check_both();
        chk("s_pixel_x", 32'(s_px), e_s.x);      chk("m_pixel_x", 32'(m_px), e_m.x);
        chk("s_pixel_y", 32'(s_py), e_s.y);      chk("m_pixel_y", 32'(m_py), e_m.y);
        chk("s_video_on", 32'(s_von), 32'(e_s.von)); chk("m_video_on", 32'(m_von), 32'(e_m.von));
        chk("s_h_sync", 32'(s_hs), 32'(e_s.hs)); chk("m_h_sync", 32'(m_hs), 32'(e_m.hs));
        chk("s_v_sync", 32'(s_vs), 32'(e_s.vs)); chk("m_v_sync", 32'(m_vs), 32'(e_m.vs));
        chk("s_line_start", 32'(s_ls), 32'(e_s.ls)); chk("m_line_start", 32'(m_ls), 32'(e_m.ls));
        chk("s_frame_over", 32'(s_fo), 32'(e_s.fo)); chk("m_frame_over", 32'(m_fo), 32'(e_m.fo));
        chk("s_vblank", 32'(s_vb), 32'(e_s.vb)); chk("m_vblank", 32'(m_vb), 32'(e_m.vb));
        chk("s_line_req", 32'(s_lr), 32'(e_s.lr)); chk("m_line_req", 32'(m_lr), 32'(e_m.lr));
        chk("s_req_y", 32'(s_ry), e_s.ry);       chk("m_req_y", 32'(m_ry), e_m.ry);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("s_frame_cnt", 32'(s_fc), e_s.fc);   chk("m_frame_cnt", 32'(m_fc), e_m.fc);
`endif
        if (s_fo === 1'b1) begin
            if (s_last_fo >= 0) chk("s_frame_period", n_en - s_last_fo, 32'd98);
            s_last_fo = n_en;
        end
        if (m_fo === 1'b1) begin
            if (m_last_fo >= 0) chk("m_frame_period", n_en - m_last_fo, 32'd1595);
            m_last_fo = n_en;
        end
    endtask

    task automatic tick(input bit en);
        bit adv;
        enable = en;
        @(posedge clk);
        adv = en && (reset_n === 1'b1);
        e_s = next_exp(e_s, adv, n_en, cs);
        e_m = next_exp(e_m, adv, n_en, cm);
        if (adv) n_en++;
        @(negedge clk);
        check_both();
    endtask

    initial begin
        cs = '{hd: 8, hfp: 2, hsw: 2, hbp: 2, vd: 4, vfp: 1, vsw: 1, vbp: 1,
               hpol: 1'b1, vpol: 1'b0, pf: 3};
        cm = '{hd: 40, hfp: 4, hsw: 6, hbp: 5, vd: 20, vfp: 2, vsw: 3, vbp: 4,
               hpol: 1'b0, vpol: 1'b0, pf: 10};
        e_s = reset_exp(cs);
        e_m = reset_exp(cm);
        reset_n = 1'b0;
        enable  = 1'b0;

        // Reset values held across edges, enable high.
        repeat (3) tick(1'b1);
        reset_n = 1'b1;

        // First edge after release shows (0,0) with the line-start pulse.
        tick(1'b1);
        chk("first_video_on", 32'(m_von), 32'd1);
        chk("first_line_start", 32'(m_ls), 32'd1);

        // Randomised enable over a couple of medium frames.
        for (int i = 0; i < 3500; i++) begin
            tick($urandom_range(0, 99) < 85);
        end

        // Freeze one position before horizontal sync, then resume.
        for (int i = 0; i < 2000; i++) begin
            if (m_px == 6'd43) break;
            tick(1'b1);
        end
        chk("freeze_pos", 32'(m_px), 32'd43);
        repeat (50) tick(1'b0);
        tick(1'b1);
        chk("resume_pixel_x", 32'(m_px), 32'd44);
        chk("resume_h_sync", 32'(m_hs), 32'd0);

        // Full enabled frames so the period checks fire back to back.
        repeat (3300) tick(1'b1);

        // Asynchronous reset mid-line, observed before any clock edge.
        for (int i = 0; i < 2000; i++) begin
            if (m_px == 6'd27 && m_py == 6'd10) break;
            tick(1'b1);
        end
        chk("reset_target_x", 32'(m_px), 32'd27);
        chk("reset_target_y", 32'(m_py), 32'd10);
        #2;
        reset_n = 1'b0;
        #1;
        e_s = reset_exp(cs);
        e_m = reset_exp(cm);
        n_en = 0;
        s_last_fo = -1;
        m_last_fo = -1;
        check_both();
        @(negedge clk);
        check_both();
        reset_n = 1'b1;
        tick(1'b1);
        chk("restart_x", 32'(m_px), 32'd0);
        chk("restart_y", 32'(m_py), 32'd0);
        chk("restart_line_start", 32'(m_ls), 32'd1);

        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 99) < 70);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
